rxdata_fifo_axis_master: RTL and testbench
==========================================

// Module: rxdata_fifo_axis_master
// PURPOSE
//  Read side of the RX path in the AXIS bridge. Pops packet descriptors from a control FIFO and
//  64-bit words from a data FIFO, and drives them as AXI-Stream master packets with tkeep/tlast/tuser.
//  Single clock domain: the read ports of both FIFOs are clocked by clk. One packet is in flight at a time.
// PARAMETERS
//  WIDTH   64         data word width (bits); must be a multiple of 8
//  KEEP_W  WIDTH/8    tkeep width (bytes per word)
//  LEN_W   16         descriptor byte-length field width
// PORTS
//  clk            in   1        single clock: FIFO read side and AXIS side
//  reset_         in   1        asynchronous, active-low reset
//  enable         in   1        1 = may start a new packet; sampled only in IDLE
//  ctrl_rden      out  1        control FIFO read request
//  ctrl_dataout   in   LEN_W+1  {err, byte_len}; valid 1 cycle after ctrl_rden
//  ctrl_rdempty   in   1        control FIFO empty
//  data_rden      out  1        data FIFO read request
//  data_dataout   in   WIDTH    data word; valid 1 cycle after data_rden; byte0 = [7:0]
//  data_rdempty   in   1        data FIFO empty
//  m_axis_tvalid  out  1        AXIS valid
//  m_axis_tready  in   1        AXIS ready
//  m_axis_tdata   out  WIDTH    AXIS data
//  m_axis_tkeep   out  KEEP_W   AXIS byte enables
//  m_axis_tlast   out  1        last beat of packet
//  m_axis_tuser   out  1        packet error flag (last beat only)
//  pkt_done       out  1        1-cycle pulse when the last beat is accepted
//  zero_len_drop  out  1        1-cycle pulse when a descriptor with byte_len==0 is discarded
// BEHAVIOUR
//  Reset (async, reset_=0): all outputs 0; state IDLE; skid buffer empty; counters cleared.
//  FIFO read latency is fixed at 1 cycle (non-FWFT). Reads never occur when the FIFO is empty.
//  FSM:
//   IDLE: if enable & !ctrl_rdempty -> ctrl_rden=1 for exactly 1 cycle -> CTRL_WAIT.
//   CTRL_WAIT: capture ctrl_dataout.
//    - len==0: zero_len_drop=1 for 1 cycle -> IDLE; no data read.
//    - else: words=ceil(len/KEEP_W); r=len%KEEP_W; last_keep = (r==0) ? all-ones : (1<<r)-1;
//      latch err; rd_left=words; beat_left=words -> STREAM.
//   STREAM: data_rden = !data_rdempty & rd_left!=0 & (buf_cnt + inflight - pop) < 2,
//    where pop = tvalid & tready this cycle and inflight = data_rden of the previous cycle.
//    Returned word is pushed into a 2-entry skid FIFO 1 cycle after its rden; the head drives tdata.
//    tvalid = (buf_cnt != 0). Once asserted, tvalid/tdata/tkeep/tlast/tuser are held until tready.
//    Non-last beat: tkeep=all-ones, tlast=0, tuser=0. Last beat (beat_left==1): tkeep=last_keep,
//    tlast=1, tuser=err.
//    On the last-beat handshake: pkt_done=1 for 1 cycle -> IDLE; the next ctrl_rden is issued no earlier
//    than the following cycle.
//  Throughput: with tready=1 and the data FIFO non-empty, 1 beat/cycle sustained; first tvalid comes 4
//   cycles after ctrl_rden (ctrl_rden, CTRL_WAIT, data_rden, push).
//  Exactly `words` data_rden pulses are issued per packet; the block never reads past the packet boundary.
//  data_rdempty mid-packet: reads stall; tvalid drops only after the buffer drains; no data loss or reorder.
//  enable=0 mid-packet: no effect until pkt_done; then the block stays in IDLE.
//  Simultaneous push and pop with buf_cnt==2 cannot occur (credit rule); buf_cnt range is 0..2.
//  Reset mid-packet: immediate abort; remaining FIFO contents are handled by the shared reset of the FIFOs.
// TESTING
//  1 len=64, err=0, tready=1 -> 8 back-to-back beats; tkeep=FF on all; tlast on beat 8 only; 1 pkt_done.
//  2 len=13, err=1 -> 2 beats, tkeep FF then 1F; tuser=1 on beat 2 only; 2 data_rden pulses.
//  3 len=0 descriptor followed by len=8 -> zero_len_drop pulse, no data_rden for the first; second packet
//    is 1 beat, tkeep=FF, tlast=1.
//  4 len=100, random tready (50%) -> 13 beats in order; last tkeep=0F; tdata stable while
//    tvalid & !tready; exactly 13 data_rden pulses.
//  5 len=40, data_rdempty forced high for 5 cycles after word 2 -> stall, then resume; 5 beats intact;
//    no rden while empty.
//  6 reset_ low during beat 3 of len=64 -> all outputs 0 asynchronously; after release, idle until the
//    next descriptor.

Source files
------------

// File: rtl/rxdata_fifo_axis_master.sv
// rtl/rxdata_fifo_axis_master.sv - RX read side: control/data FIFO pops to AXI-Stream master packets
// One packet in flight; a 2-entry skid buffer absorbs the 1-cycle FIFO read latency.
module rxdata_fifo_axis_master #(
  parameter int WIDTH  = 64,
  parameter int KEEP_W = WIDTH / 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              enable,
  output logic              ctrl_rden,
  input  logic [LEN_W:0]    ctrl_dataout,
  input  logic              ctrl_rdempty,
  output logic              data_rden,
  input  logic [WIDTH-1:0]  data_dataout,
  input  logic              data_rdempty,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [WIDTH-1:0]  m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              pkt_done,
  output logic              zero_len_drop
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CTRL_RD,
    S_CTRL_WAIT,
    S_STREAM
  } state_t;

  localparam logic [LEN_W-1:0] KEEP_L = LEN_W'(KEEP_W);

  state_t              state_q;
  logic                ctrl_rden_q;
  logic [LEN_W-1:0]    rd_left_q;
  logic [LEN_W-1:0]    beat_left_q;
  logic [KEEP_W-1:0]   last_keep_q;
  logic                err_q;
  logic                inflight_q;
  logic [WIDTH-1:0]    buf_q [2];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          buf_cnt_q;

  logic [LEN_W-1:0]    desc_len;
  logic                desc_err;
  logic [LEN_W-1:0]    desc_rem;
  logic [LEN_W-1:0]    desc_words;
  logic [KEEP_W-1:0]   desc_keep;
  logic                tvalid;
  logic                pop;
  logic                is_last;
  logic [2:0]          occ;
  logic [2:0]          occ_lim;

  assign desc_len   = ctrl_dataout[LEN_W-1:0];
  assign desc_err   = ctrl_dataout[LEN_W];
  assign desc_rem   = desc_len % KEEP_L;
  assign desc_words = (desc_len / KEEP_L) + LEN_W'(desc_rem != '0);

  always_comb begin
    desc_keep = '0;
    for (int b = 0; b < KEEP_W; b++) begin
      desc_keep[b] = (desc_rem == '0) || (LEN_W'(b) < desc_rem);
    end
  end

  assign tvalid  = (buf_cnt_q != 2'd0);
  assign pop     = tvalid && m_axis_tready;
  assign is_last = (beat_left_q == LEN_W'(1));

  // Credit: words held plus words still returning, after this cycle's pop, must stay below 2.
  assign occ     = {1'b0, buf_cnt_q} + {2'b00, inflight_q};
  assign occ_lim = 3'd2 + {2'b00, pop};

  assign data_rden = (state_q == S_STREAM) && !data_rdempty &&
                     (rd_left_q != '0) && (occ < occ_lim);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= S_IDLE;
      ctrl_rden_q <= 1'b0;
      rd_left_q   <= '0;
      beat_left_q <= '0;
      last_keep_q <= '0;
      err_q       <= 1'b0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      buf_cnt_q   <= 2'd0;
    end else begin
      ctrl_rden_q <= 1'b0;
      inflight_q  <= data_rden;
      case (state_q)
        S_IDLE: begin
          if (enable && !ctrl_rdempty) begin
            ctrl_rden_q <= 1'b1;
            state_q     <= S_CTRL_RD;
          end
        end
        S_CTRL_RD: state_q <= S_CTRL_WAIT;
        S_CTRL_WAIT: begin
          if (desc_len == '0) begin
            state_q <= S_IDLE;
          end else begin
            rd_left_q   <= desc_words;
            beat_left_q <= desc_words;
            last_keep_q <= desc_keep;
            err_q       <= desc_err;
            state_q     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (data_rden) rd_left_q <= rd_left_q - LEN_W'(1);
          if (pop) begin
            beat_left_q <= beat_left_q - LEN_W'(1);
            if (is_last) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (inflight_q) wr_ptr_q <= ~wr_ptr_q;
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      if (inflight_q && !pop) begin
        buf_cnt_q <= buf_cnt_q + 2'd1;
      end else if (!inflight_q && pop) begin
        buf_cnt_q <= buf_cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (inflight_q) buf_q[wr_ptr_q] <= data_dataout;
  end

  assign ctrl_rden     = ctrl_rden_q;
  assign m_axis_tvalid = tvalid;
  assign m_axis_tdata  = tvalid ? buf_q[rd_ptr_q] : '0;
  assign m_axis_tkeep  = !tvalid ? '0 : (is_last ? last_keep_q : '1);
  assign m_axis_tlast  = tvalid && is_last;
  assign m_axis_tuser  = tvalid && is_last && err_q;
  assign pkt_done      = (state_q == S_STREAM) && pop && is_last;
  assign zero_len_drop = (state_q == S_CTRL_WAIT) && (desc_len == '0);

endmodule

// File: tb/tb_rxdata_fifo_axis_master.sv
// tb/tb_rxdata_fifo_axis_master.sv - randomized bench with FIFO models and a packet-level beat scoreboard
module tb_rxdata_fifo_axis_master;
  localparam int WIDTH  = 64;
  localparam int KEEP_W = 8;
  localparam int LEN_W  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_, enable;
  logic              ctrl_rden, ctrl_rdempty, data_rden, data_rdempty;
  logic [LEN_W:0]    ctrl_dataout;
  logic [WIDTH-1:0]  data_dataout, m_axis_tdata;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic              m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic              pkt_done, zero_len_drop;

  rxdata_fifo_axis_master #(.WIDTH(WIDTH), .KEEP_W(KEEP_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_(reset_), .enable(enable),
    .ctrl_rden(ctrl_rden), .ctrl_dataout(ctrl_dataout), .ctrl_rdempty(ctrl_rdempty),
    .data_rden(data_rden), .data_dataout(data_dataout), .data_rdempty(data_rdempty),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .pkt_done(pkt_done), .zero_len_drop(zero_len_drop)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  beat_t          exp_beats[$];
  int             exp_words_q[$];
  logic [LEN_W:0] ctrl_q[$];
  logic [63:0]    data_q[$];

  int checks, errors;
  int exp_drops, seen_drops;
  int cyc, ctrl_cyc, lat, first_hs, last_hs, pkt_rden, pkt_beats;
  int done_beats, done_rden, done_lat, done_span;
  logic [7:0] done_keep;
  logic done_user;
  bit seen_valid, prev_stall, cr_s, dr_s;
  bit force_empty, rand_phase, rand_mode;
  beat_t prev;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic void update_empty();
    ctrl_rdempty = (ctrl_q.size() == 0);
    data_rdempty = (data_q.size() == 0) || force_empty;
  endfunction

  task automatic enqueue(input int len, input bit err);
    int words, bytes;
    beat_t b;
    ctrl_q.push_back({err, 16'(len)});
    if (len == 0) begin
      exp_drops++;
    end else begin
      words = (len + 7) / 8;
      bytes = len - 8 * (words - 1);
      for (int i = 0; i < words; i++) begin
        b.d = {$urandom, $urandom};
        data_q.push_back(b.d);
        b.l = (i == words - 1);
        b.k = b.l ? 8'((1 << bytes) - 1) : 8'hFF;
        b.u = b.l & err;
        exp_beats.push_back(b);
      end
      exp_words_q.push_back(words);
    end
    update_empty();
  endtask

  // Compares every sampled cycle against the scoreboard.
  task automatic compare();
    beat_t e;
    cyc++;
    cr_s = ctrl_rden;
    dr_s = data_rden;
    if (!reset_) begin
      prev_stall = 0; seen_valid = 0; pkt_rden = 0; pkt_beats = 0;
      return;
    end
    if (data_rden) begin
      chk("data_rden_while_empty", data_rdempty, 0);
      pkt_rden++;
    end
    if (ctrl_rden) begin
      chk("ctrl_rden_while_empty", ctrl_rdempty, 0);
      ctrl_cyc = cyc;
    end
    if (zero_len_drop) seen_drops++;
    if (prev_stall) begin
      chk("hold_tvalid", m_axis_tvalid, 1);
      chk("hold_tdata", m_axis_tdata, prev.d);
      chk("hold_tkeep", m_axis_tkeep, prev.k);
      chk("hold_tlast_tuser", {m_axis_tlast, m_axis_tuser}, {prev.l, prev.u});
    end
    if (m_axis_tvalid && !seen_valid) begin
      seen_valid = 1;
      lat = cyc - ctrl_cyc;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_beats.size() == 0) begin
        chk("unexpected_beat", m_axis_tvalid & m_axis_tready, 0);
      end else begin
        e = exp_beats.pop_front();
        chk("tdata", m_axis_tdata, e.d);
        chk("tkeep", m_axis_tkeep, e.k);
        chk("tlast", m_axis_tlast, e.l);
        chk("tuser", m_axis_tuser, e.u);
        chk("pkt_done", pkt_done, e.l);
        if (pkt_beats == 0) first_hs = cyc;
        last_hs = cyc;
        pkt_beats++;
        if (e.l) begin
          if (exp_words_q.size() != 0) chk("rden_count", pkt_rden, exp_words_q.pop_front());
          done_beats = pkt_beats; done_rden = pkt_rden; done_lat = lat;
          done_span = last_hs - first_hs; done_keep = m_axis_tkeep; done_user = m_axis_tuser;
          pkt_beats = 0; pkt_rden = 0; seen_valid = 0;
        end
      end
    end else begin
      chk("pkt_done_idle", pkt_done, 0);
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    if (reset_ && cr_s && ctrl_q.size() != 0) ctrl_dataout = ctrl_q.pop_front();
    if (reset_ && dr_s && data_q.size() != 0) data_dataout = data_q.pop_front();
    m_axis_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rand_phase) begin
      force_empty = ($urandom_range(0, 3) == 0);
      enable      = ($urandom_range(0, 3) != 0);
    end
    update_empty();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_beats.size() != 0 || ctrl_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_within_budget", (n < budget), 1);
    repeat (4) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_tdata"}, m_axis_tdata, 0);
    chk({tag, "_tkeep"}, m_axis_tkeep, 0);
    chk({tag, "_tlast_tuser"}, {m_axis_tlast, m_axis_tuser}, 0);
    chk({tag, "_rden"}, {ctrl_rden, data_rden}, 0);
    chk({tag, "_pulses"}, {pkt_done, zero_len_drop}, 0);
  endtask

  initial begin
    int d0, n, seen;
    checks = 0; errors = 0; exp_drops = 0; seen_drops = 0; cyc = 0; ctrl_cyc = 0;
    reset_ = 1'b0; enable = 1'b0; m_axis_tready = 1'b0;
    force_empty = 0; rand_phase = 0; rand_mode = 0;
    ctrl_dataout = '0; data_dataout = '0;
    update_empty();
    #1;
    check_outputs_zero("reset");
    repeat (3) tick();
    reset_ = 1'b1;
    enable = 1'b1;

    enqueue(64, 0);
    wait_idle(500);
    chk("t1_beats", done_beats, 8);
    chk("t1_rden", done_rden, 8);
    chk("t1_last_keep", done_keep, 8'hFF);
    chk("t1_first_valid_latency", done_lat, 4);
    chk("t1_back_to_back_span", done_span, 7);

    enqueue(13, 1);
    wait_idle(500);
    chk("t2_beats", done_beats, 2);
    chk("t2_rden", done_rden, 2);
    chk("t2_last_keep", done_keep, 8'h1F);
    chk("t2_last_tuser", done_user, 1);

    d0 = seen_drops;
    enqueue(0, 0);
    enqueue(8, 0);
    wait_idle(500);
    chk("t3_drop_pulses", seen_drops - d0, 1);
    chk("t3_beats", done_beats, 1);
    chk("t3_rden", done_rden, 1);
    chk("t3_keep", done_keep, 8'hFF);

    rand_mode = 1;
    enqueue(100, 0);
    wait_idle(2000);
    chk("t4_beats", done_beats, 13);
    chk("t4_rden", done_rden, 13);
    chk("t4_last_keep", done_keep, 8'h0F);
    rand_mode = 0;

    enqueue(40, 0);
    n = 0; seen = 0;
    while (seen < 2 && n < 100) begin
      tick();
      if (dr_s) seen++;
      n++;
    end
    chk("t5_two_reads_seen", seen, 2);
    force_empty = 1; update_empty();
    repeat (5) tick();
    force_empty = 0; update_empty();
    wait_idle(500);
    chk("t5_beats", done_beats, 5);
    chk("t5_rden", done_rden, 5);
    chk("t5_last_keep", done_keep, 8'hFF);

    enqueue(64, 0);
    n = 0;
    while (pkt_beats < 2 && n < 200) begin
      tick();
      n++;
    end
    chk("t6_reached_beat3", pkt_beats, 2);
    #2;
    reset_ = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_beats.delete(); exp_words_q.delete(); ctrl_q.delete(); data_q.delete();
    ctrl_dataout = '0; data_dataout = '0;
    update_empty();
    repeat (2) tick();
    reset_ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_idle_tvalid", m_axis_tvalid, 0);
      chk("t6_idle_rden", {ctrl_rden, data_rden}, 0);
    end
    enqueue(21, 1);
    wait_idle(500);
    chk("t6_after_beats", done_beats, 3);
    chk("t6_after_keep", done_keep, 8'h1F);

    rand_phase = 1; rand_mode = 1;
    for (int p = 0; p < 25; p++) begin
      enqueue(($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 100)), 1'($urandom_range(0, 1)));
    end
    wait_idle(20000);
    rand_phase = 0; rand_mode = 0; force_empty = 0; enable = 1'b1;
    update_empty();
    repeat (4) tick();
    chk("zero_len_drop_total", seen_drops, exp_drops);
    chk("scoreboard_empty", exp_beats.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
